chunk_pingpong_buffer: RTL and testbench

Parametrised multi-channel ping-pong chunk buffer between the I2S receiver, the block processor and the I2S transmitter. It captures interleaved per-channel samples into one capture bank while the processor reads the other. Processed samples are written into an output bank while the transmitter plays the other. It generalises the left-only 64-sample flush scheme to N channels and arbitrary depth, and adds processor-completion tracking and overrun detection.

---
 rtl/dsp_pkg.sv | 19 +
 rtl/chunk_ram.sv | 56 +++++
 rtl/chunk_pingpong_buffer.sv | 145 ++++++++++++++
 tb/tb_chunk_pingpong_buffer.sv | 396 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dsp_pkg.sv
// Shared audio DSP defaults and the chunk RAM bank address layout.
// Entries are ordered {bank, frame, ch}, with channel as the fastest index.
package dsp_pkg;

    localparam int SAMPLE_W_DEF = 24;
    localparam int DEPTH_DEF    = 64;
    localparam int CHANNELS_DEF = 2;

    function automatic int unsigned ram_addr(
        input int unsigned bank,
        input int unsigned frame,
        input int unsigned ch,
        input int unsigned depth,
        input int unsigned channels
    );
        return (bank * depth + frame) * channels + ch;
    endfunction

endpackage

// File: rtl/chunk_ram.sv
// Two-bank sample RAM: one write port, one read port with a registered output.
// Out-of-range addresses (non power-of-two channel counts) are ignored on write and read as zero.
module chunk_ram
    import dsp_pkg::*;
#(
    parameter int W       = SAMPLE_W_DEF,
    parameter int ENTRIES = 2 * DEPTH_DEF * CHANNELS_DEF,
    localparam int AW     = $clog2(ENTRIES)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [W-1:0]  wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [W-1:0]  rd_data
);

    logic [W-1:0] mem [ENTRIES];
    logic [W-1:0] rd_data_d;
    logic [W-1:0] rd_data_q;
    logic         wr_ok;
    logic         rd_ok;

    if (ENTRIES == (1 << AW)) begin : g_full
        assign wr_ok = 1'b1;
        assign rd_ok = 1'b1;
    end else begin : g_part
        assign wr_ok = (wr_addr < AW'(ENTRIES));
        assign rd_ok = (rd_addr < AW'(ENTRIES));
    end

    always_ff @(posedge clk) begin
        if (wr_en && wr_ok) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        rd_data_d = '0;
        if (rd_ok) begin
            rd_data_d = mem[rd_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/chunk_pingpong_buffer.sv
// Multi-channel ping-pong chunk buffer between I2S capture, block processor and I2S playback.
// Capture and playback share bank `sel`; the processor always works on the opposite bank.
module chunk_pingpong_buffer
    import dsp_pkg::*;
#(
    parameter int SAMPLE_W  = SAMPLE_W_DEF,
    parameter int DEPTH     = DEPTH_DEF,
    parameter int CHANNELS  = CHANNELS_DEF,
    localparam int ADDR_W   = $clog2(DEPTH),
    localparam int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    input  logic [CH_W-1:0]     in_ch,
    input  logic [SAMPLE_W-1:0] in_sample,
    output logic                chunk_start,
    input  logic [ADDR_W-1:0]   proc_rd_addr,
    input  logic [CH_W-1:0]     proc_rd_ch,
    output logic [SAMPLE_W-1:0] proc_rd_data,
    input  logic                proc_wr_en,
    input  logic [ADDR_W-1:0]   proc_wr_addr,
    input  logic [CH_W-1:0]     proc_wr_ch,
    input  logic [SAMPLE_W-1:0] proc_wr_data,
    input  logic                proc_done,
    input  logic [CH_W-1:0]     tx_ch,
    output logic [SAMPLE_W-1:0] tx_sample,
    output logic [ADDR_W-1:0]   frame_idx,
    output logic                busy,
    output logic                overrun
);

    localparam int ENTRIES = 2 * DEPTH * CHANNELS;
    localparam int RAM_AW  = $clog2(ENTRIES);

    localparam logic [CH_W-1:0]   CH_LAST    = CH_W'(CHANNELS - 1);
    localparam logic [ADDR_W-1:0] FRAME_LAST = ADDR_W'(DEPTH - 1);

    logic              sel_q, sel_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic              busy_q, busy_d;
    logic              overrun_q, overrun_d;
    logic              chunk_start_q, chunk_start_d;

    logic              accept;
    logic              last_ch;
    logic              wrap;
    logic              busy_after_done;
    logic              proc_bank;

    logic [RAM_AW-1:0] cap_waddr;
    logic [RAM_AW-1:0] cap_raddr;
    logic [RAM_AW-1:0] out_waddr;
    logic [RAM_AW-1:0] out_raddr;

    assign proc_bank = ~sel_q;

    always_comb begin
        accept  = in_valid && (in_ch <= CH_LAST) && !rst;
        last_ch = accept && (in_ch == CH_LAST);
        wrap    = last_ch && (wr_ptr_q == FRAME_LAST);
    end

    always_comb begin
        sel_d           = sel_q;
        wr_ptr_d        = wr_ptr_q;
        overrun_d       = overrun_q;
        chunk_start_d   = wrap;
        busy_after_done = busy_q && !proc_done;
        busy_d          = busy_after_done;

        if (last_ch) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end

        // A completion in the wrap cycle frees the processor before the new chunk claims it.
        if (wrap) begin
            wr_ptr_d = '0;
            sel_d    = ~sel_q;
            busy_d   = 1'b1;
            if (busy_after_done) begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sel_q         <= 1'b0;
            wr_ptr_q      <= '0;
            busy_q        <= 1'b0;
            overrun_q     <= 1'b0;
            chunk_start_q <= 1'b0;
        end else begin
            sel_q         <= sel_d;
            wr_ptr_q      <= wr_ptr_d;
            busy_q        <= busy_d;
            overrun_q     <= overrun_d;
            chunk_start_q <= chunk_start_d;
        end
    end

    always_comb begin
        cap_waddr = RAM_AW'(ram_addr(32'(sel_q), 32'(wr_ptr_q), 32'(in_ch),
                                     DEPTH, CHANNELS));
        cap_raddr = RAM_AW'(ram_addr(32'(proc_bank), 32'(proc_rd_addr),
                                     32'(proc_rd_ch), DEPTH, CHANNELS));
        out_waddr = RAM_AW'(ram_addr(32'(proc_bank), 32'(proc_wr_addr),
                                     32'(proc_wr_ch), DEPTH, CHANNELS));
        out_raddr = RAM_AW'(ram_addr(32'(sel_q), 32'(wr_ptr_q), 32'(tx_ch),
                                     DEPTH, CHANNELS));
    end

    chunk_ram #(
        .W       (SAMPLE_W),
        .ENTRIES (ENTRIES)
    ) u_cap_ram (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (accept),
        .wr_addr (cap_waddr),
        .wr_data (in_sample),
        .rd_addr (cap_raddr),
        .rd_data (proc_rd_data)
    );

    chunk_ram #(
        .W       (SAMPLE_W),
        .ENTRIES (ENTRIES)
    ) u_out_ram (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (proc_wr_en && !rst),
        .wr_addr (out_waddr),
        .wr_data (proc_wr_data),
        .rd_addr (out_raddr),
        .rd_data (tx_sample)
    );

    assign chunk_start = chunk_start_q;
    assign frame_idx   = wr_ptr_q;
    assign busy        = busy_q;
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_chunk_pingpong_buffer.sv
// Bench for chunk_pingpong_buffer: directed scenarios plus a randomized run
// checked against a chunk/frame-level reference model.
module tb_chunk_pingpong_buffer;

    localparam int SW = 24;
    localparam int D  = 4;
    localparam int C  = 2;
    localparam int AW = 2;
    localparam int CW = 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          in_valid = 1'b0;
    logic [CW-1:0] in_ch = '0;
    logic [SW-1:0] in_sample = '0;
    logic          chunk_start;
    logic [AW-1:0] proc_rd_addr = '0;
    logic [CW-1:0] proc_rd_ch = '0;
    logic [SW-1:0] proc_rd_data;
    logic          proc_wr_en = 1'b0;
    logic [AW-1:0] proc_wr_addr = '0;
    logic [CW-1:0] proc_wr_ch = '0;
    logic [SW-1:0] proc_wr_data = '0;
    logic          proc_done = 1'b0;
    logic [CW-1:0] tx_ch = '0;
    logic [SW-1:0] tx_sample;
    logic [AW-1:0] frame_idx;
    logic          busy;
    logic          overrun;

    chunk_pingpong_buffer #(
        .SAMPLE_W (SW),
        .DEPTH    (D),
        .CHANNELS (C)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ch        (in_ch),
        .in_sample    (in_sample),
        .chunk_start  (chunk_start),
        .proc_rd_addr (proc_rd_addr),
        .proc_rd_ch   (proc_rd_ch),
        .proc_rd_data (proc_rd_data),
        .proc_wr_en   (proc_wr_en),
        .proc_wr_addr (proc_wr_addr),
        .proc_wr_ch   (proc_wr_ch),
        .proc_wr_data (proc_wr_data),
        .proc_done    (proc_done),
        .tx_ch        (tx_ch),
        .tx_sample    (tx_sample),
        .frame_idx    (frame_idx),
        .busy         (busy),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    // Reference model: chunks as arrays, capture position as (bank, frame).
    logic [SW-1:0] cap  [2][D][C];
    bit            capk [2][D][C];
    logic [SW-1:0] outm [2][D][C];
    bit            outk [2][D][C];
    int            m_bank, m_ptr;
    bit            m_busy, m_ovr, m_cs;
    logic [SW-1:0] e_rd, e_tx;
    bit            e_rdk, e_txk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic tick();
        int  pb, pp;
        bit  wrap, b;
        pb   = m_bank;
        pp   = m_ptr;
        wrap = 0;
        if (rst) begin
            m_bank = 0; m_ptr = 0; m_busy = 0; m_ovr = 0; m_cs = 0;
            e_rd = '0; e_rdk = 1; e_tx = '0; e_txk = 1;
        end else begin
            e_rd  = cap[1-pb][proc_rd_addr][proc_rd_ch];
            e_rdk = capk[1-pb][proc_rd_addr][proc_rd_ch];
            e_tx  = outm[pb][pp][tx_ch];
            e_txk = outk[pb][pp][tx_ch];
            if (proc_wr_en) begin
                outm[1-pb][proc_wr_addr][proc_wr_ch] = proc_wr_data;
                outk[1-pb][proc_wr_addr][proc_wr_ch] = 1;
            end
            if (in_valid && int'(in_ch) < C) begin
                cap[pb][pp][in_ch]  = in_sample;
                capk[pb][pp][in_ch] = 1;
                if (int'(in_ch) == C - 1) begin
                    if (pp == D - 1) wrap = 1;
                    m_ptr = (pp + 1) % D;
                end
            end
            b = m_busy;
            if (proc_done) b = 0;
            if (wrap) begin
                if (b) m_ovr = 1;
                b = 1;
                m_bank = 1 - pb;
            end
            m_busy = b;
            m_cs   = wrap;
        end
        @(posedge clk);
        #1;
        in_valid   = 1'b0;
        proc_wr_en = 1'b0;
        proc_done  = 1'b0;
    endtask

    task automatic cap_smp(input int ch, input logic [SW-1:0] v);
        in_valid  = 1'b1;
        in_ch     = CW'(ch);
        in_sample = v;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        n_cmp += 6;
        if (chunk_start !== 1'b0) begin
            n_bad++; $display("FAIL reset_chunk_start got %0h want 0", chunk_start);
        end
        if (frame_idx !== '0) begin
            n_bad++; $display("FAIL reset_frame_idx got %0h want 0", frame_idx);
        end
        if (busy !== 1'b0) begin
            n_bad++; $display("FAIL reset_busy got %0h want 0", busy);
        end
        if (overrun !== 1'b0) begin
            n_bad++; $display("FAIL reset_overrun got %0h want 0", overrun);
        end
        if (proc_rd_data !== '0) begin
            n_bad++; $display("FAIL reset_rd_data got %0h want 0", proc_rd_data);
        end
        if (tx_sample !== '0) begin
            n_bad++; $display("FAIL reset_tx_sample got %0h want 0", tx_sample);
        end
    endtask

    task automatic test_fill();
        int want_fi;
        for (int k = 1; k <= 8; k++) begin
            cap_smp((k - 1) % 2, SW'(k));
            want_fi = (k / 2) % D;
            n_cmp += 2;
            if (frame_idx !== AW'(want_fi)) begin
                n_bad++;
                $display("FAIL fill_frame_idx[%0d] got %0d want %0d", k, frame_idx, want_fi);
            end
            if (chunk_start !== (k == 8)) begin
                n_bad++;
                $display("FAIL fill_chunk_start[%0d] got %0h want %0h", k, chunk_start, k == 8);
            end
        end
        n_cmp++;
        if (busy !== 1'b1) begin
            n_bad++; $display("FAIL fill_busy got %0h want 1", busy);
        end
        tick();
        n_cmp++;
        if (chunk_start !== 1'b0) begin
            n_bad++; $display("FAIL fill_pulse_width got %0h want 0", chunk_start);
        end
    endtask

    task automatic test_readback();
        proc_rd_addr = 2'd2;
        proc_rd_ch   = 1'b1;
        cap_smp(0, 24'h000009);
        n_cmp += 2;
        if (proc_rd_data !== 24'h000006) begin
            n_bad++; $display("FAIL readback_data got %0h want 000006", proc_rd_data);
        end
        if (frame_idx !== 2'd0) begin
            n_bad++; $display("FAIL readback_frame_idx got %0d want 0", frame_idx);
        end
    endtask

    task automatic test_output_path();
        proc_wr_en   = 1'b1;
        proc_wr_addr = 2'd1;
        proc_wr_ch   = 1'b0;
        proc_wr_data = 24'hABCDEF;
        tick();
        proc_done = 1'b1;
        tick();
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++; $display("FAIL out_done_busy got %0h want 0", busy);
        end
        for (int k = 0; k < 7; k++) begin
            cap_smp((k % 2 == 0) ? 1 : 0, SW'(10 + k));
        end
        n_cmp += 3;
        if (chunk_start !== 1'b1) begin
            n_bad++; $display("FAIL out_chunk2_start got %0h want 1", chunk_start);
        end
        if (busy !== 1'b1) begin
            n_bad++; $display("FAIL out_chunk2_busy got %0h want 1", busy);
        end
        if (overrun !== 1'b0) begin
            n_bad++; $display("FAIL out_chunk2_overrun got %0h want 0", overrun);
        end
        cap_smp(0, 24'h000011);
        cap_smp(1, 24'h000012);
        tx_ch = 1'b0;
        tick();
        n_cmp += 2;
        if (tx_sample !== 24'hABCDEF) begin
            n_bad++; $display("FAIL out_tx_sample got %0h want abcdef", tx_sample);
        end
        if (!e_txk || tx_sample !== e_tx) begin
            n_bad++; $display("FAIL out_tx_model got %0h want %0h", tx_sample, e_tx);
        end
    endtask

    task automatic test_done_before_wrap();
        proc_done = 1'b1;
        tick();
        for (int k = 0; k < 6; k++) begin
            cap_smp(k % 2, SW'(32 + k));
        end
        n_cmp += 3;
        if (chunk_start !== 1'b1) begin
            n_bad++; $display("FAIL dbw_chunk_start got %0h want 1", chunk_start);
        end
        if (busy !== 1'b1) begin
            n_bad++; $display("FAIL dbw_busy got %0h want 1", busy);
        end
        if (overrun !== 1'b0) begin
            n_bad++; $display("FAIL dbw_overrun got %0h want 0", overrun);
        end
    endtask

    task automatic test_wrap_collide();
        for (int k = 0; k < 7; k++) begin
            cap_smp(k % 2, SW'(48 + k));
        end
        proc_done    = 1'b1;
        proc_wr_en   = 1'b1;
        proc_wr_addr = 2'd2;
        proc_wr_ch   = 1'b1;
        proc_wr_data = 24'h5A5A5A;
        cap_smp(1, 24'h000037);
        n_cmp += 3;
        if (chunk_start !== 1'b1) begin
            n_bad++; $display("FAIL wc_chunk_start got %0h want 1", chunk_start);
        end
        if (busy !== 1'b1) begin
            n_bad++; $display("FAIL wc_busy got %0h want 1", busy);
        end
        if (overrun !== 1'b0) begin
            n_bad++; $display("FAIL wc_overrun got %0h want 0", overrun);
        end
        for (int k = 0; k < 4; k++) begin
            cap_smp(k % 2, SW'(64 + k));
        end
        tx_ch = 1'b1;
        tick();
        n_cmp++;
        if (tx_sample !== 24'h5A5A5A) begin
            n_bad++; $display("FAIL wc_tx_sample got %0h want 5a5a5a", tx_sample);
        end
    endtask

    task automatic test_overrun();
        for (int k = 0; k < 4; k++) begin
            cap_smp(k % 2, SW'(80 + k));
        end
        n_cmp += 2;
        if (overrun !== 1'b1) begin
            n_bad++; $display("FAIL ovr_set got %0h want 1", overrun);
        end
        if (chunk_start !== 1'b1) begin
            n_bad++; $display("FAIL ovr_chunk_start got %0h want 1", chunk_start);
        end
        proc_done = 1'b1;
        tick();
        for (int k = 0; k < 2 * D; k++) begin
            cap_smp(k % 2, SW'(96 + k));
            n_cmp++;
            if (overrun !== 1'b1) begin
                n_bad++; $display("FAIL ovr_sticky[%0d] got %0h want 1", k, overrun);
            end
        end
    endtask

    task automatic test_reset_mid();
        bit seen_cs;
        seen_cs = 0;
        for (int k = 0; k < 6; k++) begin
            cap_smp(k % 2, SW'(128 + k));
            if (chunk_start) seen_cs = 1;
        end
        n_cmp++;
        if (frame_idx !== 2'd3) begin
            n_bad++; $display("FAIL rmid_pre_frame_idx got %0d want 3", frame_idx);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        if (chunk_start) seen_cs = 1;
        n_cmp += 5;
        if (frame_idx !== '0) begin
            n_bad++; $display("FAIL rmid_frame_idx got %0d want 0", frame_idx);
        end
        if (busy !== 1'b0 || overrun !== 1'b0) begin
            n_bad++; $display("FAIL rmid_flags got %0h%0h want 00", busy, overrun);
        end
        if (proc_rd_data !== '0) begin
            n_bad++; $display("FAIL rmid_rd_data got %0h want 0", proc_rd_data);
        end
        if (tx_sample !== '0) begin
            n_bad++; $display("FAIL rmid_tx_sample got %0h want 0", tx_sample);
        end
        for (int k = 0; k < 4; k++) begin
            tick();
            if (chunk_start) seen_cs = 1;
        end
        if (seen_cs) begin
            n_bad++; $display("FAIL rmid_chunk_start got 1 want 0");
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            in_valid     = ($urandom % 4) != 0;
            in_ch        = CW'($urandom);
            in_sample    = SW'($urandom);
            proc_rd_addr = AW'($urandom);
            proc_rd_ch   = CW'($urandom);
            proc_wr_en   = ($urandom % 3) == 0;
            proc_wr_addr = AW'($urandom);
            proc_wr_ch   = CW'($urandom);
            proc_wr_data = SW'($urandom);
            proc_done    = ($urandom % 12) == 0;
            tx_ch        = CW'($urandom);
            tick();
            n_cmp += 4;
            if (chunk_start !== m_cs) begin
                n_bad++; $display("FAIL rnd_chunk_start[%0d] got %0h want %0h", i, chunk_start, m_cs);
            end
            if (frame_idx !== AW'(m_ptr)) begin
                n_bad++; $display("FAIL rnd_frame_idx[%0d] got %0d want %0d", i, frame_idx, m_ptr);
            end
            if (busy !== m_busy) begin
                n_bad++; $display("FAIL rnd_busy[%0d] got %0h want %0h", i, busy, m_busy);
            end
            if (overrun !== m_ovr) begin
                n_bad++; $display("FAIL rnd_overrun[%0d] got %0h want %0h", i, overrun, m_ovr);
            end
            if (e_rdk) begin
                n_cmp++;
                if (proc_rd_data !== e_rd) begin
                    n_bad++; $display("FAIL rnd_rd_data[%0d] got %0h want %0h", i, proc_rd_data, e_rd);
                end
            end
            if (e_txk) begin
                n_cmp++;
                if (tx_sample !== e_tx) begin
                    n_bad++; $display("FAIL rnd_tx_sample[%0d] got %0h want %0h", i, tx_sample, e_tx);
                end
            end
        end
    endtask

    initial begin
        m_bank = 0; m_ptr = 0; m_busy = 0; m_ovr = 0; m_cs = 0;
        for (int b = 0; b < 2; b++)
            for (int f = 0; f < D; f++)
                for (int c = 0; c < C; c++) begin
                    capk[b][f][c] = 0;
                    outk[b][f][c] = 0;
                end
        test_reset();
        test_fill();
        test_readback();
        test_output_path();
        test_done_before_wrap();
        test_wrap_collide();
        test_overrun();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
